// File: rtl/decode_exec_stage.sv
// Decode-to-execute pipeline register with load-use interlock, branch flush,
// writeback bypass into captured and held operands, and a saturating bubble counter.
module decode_exec_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NREAD  = 3,
   parameter int CTRL_W = 8,
   parameter int PC_IDX = 15,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [NREAD*ADDR_W-1:0]  in_ra,
   input  logic [NREAD-1:0]         in_ra_used,
   input  logic [NREAD*DATA_W-1:0]  in_rd,
   input  logic [DATA_W-1:0]        in_ext,
   input  logic [ADDR_W-1:0]        in_wa,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [3:0]               in_cond,
   input  logic                     in_regwrite,
   input  logic                     in_memtoreg,
   input  logic                     in_branch,
   input  logic                     ex_stall,
   input  logic                     branch_taken,
   input  logic                     wb_we,
   input  logic [ADDR_W-1:0]        wb_wa,
   input  logic [DATA_W-1:0]        wb_wd,
   output logic                     out_valid,
   output logic                     out_regwrite,
   output logic                     out_memtoreg,
   output logic                     out_branch,
   output logic [NREAD*DATA_W-1:0]  out_rd,
   output logic [NREAD*ADDR_W-1:0]  out_ra,
   output logic [DATA_W-1:0]        out_ext,
   output logic [ADDR_W-1:0]        out_wa,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [3:0]               out_cond,
   output logic                     stall_d,
   output logic                     flush_d,
   output logic [CNT_W-1:0]         bubble_cnt
);

   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic                    load_use;
   logic                    bubble;
   logic                    wb_ok;
   logic [NREAD*DATA_W-1:0] cap_rd;
   logic [NREAD*DATA_W-1:0] hold_rd;

   // The PC register is never a real hazard or bypass target.
   always_comb begin
      load_use = 1'b0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         if (in_ra_used[i] && (in_ra[i*ADDR_W +: ADDR_W] == out_wa))
            load_use = 1'b1;
      end
      load_use = load_use & in_valid & out_valid & out_regwrite & out_memtoreg
                 & (out_wa != PC_A);
   end

   assign wb_ok = wb_we & (wb_wa != PC_A);

   always_comb begin
      cap_rd  = in_rd;
      hold_rd = out_rd;
      for (int unsigned i = 0; i < NREAD; i++) begin
         if (wb_ok && (wb_wa == in_ra[i*ADDR_W +: ADDR_W]))
            cap_rd[i*DATA_W +: DATA_W] = wb_wd;
         if (wb_ok && (wb_wa == out_ra[i*ADDR_W +: ADDR_W]))
            hold_rd[i*DATA_W +: DATA_W] = wb_wd;
      end
   end

   assign bubble  = ~ex_stall & (branch_taken | load_use);
   assign stall_d = ex_stall | (~branch_taken & load_use);
   assign flush_d = ~ex_stall & branch_taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_regwrite <= 1'b0;
         out_memtoreg <= 1'b0;
         out_branch   <= 1'b0;
         out_rd       <= '0;
         out_ra       <= '0;
         out_ext      <= '0;
         out_wa       <= '0;
         out_ctrl     <= '0;
         out_cond     <= '0;
         bubble_cnt   <= '0;
      end else if (ex_stall) begin
         out_rd <= hold_rd;
      end else if (bubble) begin
         out_valid    <= 1'b0;
         out_regwrite <= 1'b0;
         out_memtoreg <= 1'b0;
         out_branch   <= 1'b0;
         out_rd       <= '0;
         out_ra       <= '0;
         out_ext      <= '0;
         out_wa       <= '0;
         out_ctrl     <= '0;
         out_cond     <= '0;
         if (bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
         out_valid    <= in_valid;
         out_regwrite <= in_valid & in_regwrite;
         out_memtoreg <= in_valid & in_memtoreg;
         out_branch   <= in_valid & in_branch;
         out_rd       <= cap_rd;
         out_ra       <= in_ra;
         out_ext      <= in_ext;
         out_wa       <= in_wa;
         out_ctrl     <= in_ctrl;
         out_cond     <= in_cond;
      end
   end

endmodule

// File: tb/tb_decode_exec_stage.sv
// Randomized and directed bench for decode_exec_stage against a behavioural model
// of the E register, hazard rules and bubble counters.
module tb_decode_exec_stage;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NREAD  = 3;
   localparam int CTRL_W = 8;
   localparam int PC     = 15;

   logic                    clk, reset;
   logic                    in_valid;
   logic [NREAD*ADDR_W-1:0] in_ra;
   logic [NREAD-1:0]        in_ra_used;
   logic [NREAD*DATA_W-1:0] in_rd;
   logic [DATA_W-1:0]       in_ext;
   logic [ADDR_W-1:0]       in_wa;
   logic [CTRL_W-1:0]       in_ctrl;
   logic [3:0]              in_cond;
   logic                    in_regwrite, in_memtoreg, in_branch;
   logic                    ex_stall, branch_taken, wb_we;
   logic [ADDR_W-1:0]       wb_wa;
   logic [DATA_W-1:0]       wb_wd;
   logic                    out_valid, out_regwrite, out_memtoreg, out_branch;
   logic [NREAD*DATA_W-1:0] out_rd;
   logic [NREAD*ADDR_W-1:0] out_ra;
   logic [DATA_W-1:0]       out_ext;
   logic [ADDR_W-1:0]       out_wa;
   logic [CTRL_W-1:0]       out_ctrl;
   logic [3:0]              out_cond;
   logic                    stall_d, flush_d;
   logic [15:0]             bubble_cnt;

   logic                    s_valid, s_regwrite, s_memtoreg, s_branch;
   logic [NREAD*DATA_W-1:0] s_rd;
   logic [NREAD*ADDR_W-1:0] s_ra;
   logic [DATA_W-1:0]       s_ext;
   logic [ADDR_W-1:0]       s_wa;
   logic [CTRL_W-1:0]       s_ctrl;
   logic [3:0]              s_cond;
   logic                    s_stall_d, s_flush_d;
   logic [1:0]              s_cnt;

   int checks = 0;
   int errors = 0;

   decode_exec_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ra(in_ra), .in_ra_used(in_ra_used),
      .in_rd(in_rd), .in_ext(in_ext), .in_wa(in_wa), .in_ctrl(in_ctrl), .in_cond(in_cond),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_branch(in_branch),
      .ex_stall(ex_stall), .branch_taken(branch_taken), .wb_we(wb_we), .wb_wa(wb_wa),
      .wb_wd(wb_wd), .out_valid(out_valid), .out_regwrite(out_regwrite),
      .out_memtoreg(out_memtoreg), .out_branch(out_branch), .out_rd(out_rd), .out_ra(out_ra),
      .out_ext(out_ext), .out_wa(out_wa), .out_ctrl(out_ctrl), .out_cond(out_cond),
      .stall_d(stall_d), .flush_d(flush_d), .bubble_cnt(bubble_cnt)
   );

   decode_exec_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ra(in_ra), .in_ra_used(in_ra_used),
      .in_rd(in_rd), .in_ext(in_ext), .in_wa(in_wa), .in_ctrl(in_ctrl), .in_cond(in_cond),
      .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_branch(in_branch),
      .ex_stall(ex_stall), .branch_taken(branch_taken), .wb_we(wb_we), .wb_wa(wb_wa),
      .wb_wd(wb_wd), .out_valid(s_valid), .out_regwrite(s_regwrite),
      .out_memtoreg(s_memtoreg), .out_branch(s_branch), .out_rd(s_rd), .out_ra(s_ra),
      .out_ext(s_ext), .out_wa(s_wa), .out_ctrl(s_ctrl), .out_cond(s_cond),
      .stall_d(s_stall_d), .flush_d(s_flush_d), .bubble_cnt(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the E register.
   logic              m_valid, m_rw, m_mtr, m_br;
   logic [DATA_W-1:0] m_rd [NREAD];
   logic [ADDR_W-1:0] m_ra [NREAD];
   logic [DATA_W-1:0] m_ext;
   logic [ADDR_W-1:0] m_wa;
   logic [CTRL_W-1:0] m_ctrl;
   logic [3:0]        m_cond;
   int unsigned       m_cnt, m_cnt_sat;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [ADDR_W-1:0] src(input int i);
      return in_ra[i*ADDR_W +: ADDR_W];
   endfunction

   function automatic logic wb_hits(input logic [ADDR_W-1:0] a);
      return wb_we && (wb_wa == a) && (wb_wa != ADDR_W'(PC));
   endfunction

   function automatic logic model_lu();
      logic hit = 1'b0;
      for (int i = 0; i < NREAD; i++)
         if (in_ra_used[i] && src(i) == m_wa) hit = 1'b1;
      return hit && in_valid && m_valid && m_rw && m_mtr && (m_wa != ADDR_W'(PC));
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_mtr = 0; m_br = 0;
      m_ext = '0; m_wa = '0; m_ctrl = '0; m_cond = '0;
      for (int i = 0; i < NREAD; i++) begin m_rd[i] = '0; m_ra[i] = '0; end
   endtask

   task automatic model_edge(input logic lu);
      if (ex_stall) begin
         for (int i = 0; i < NREAD; i++) if (wb_hits(m_ra[i])) m_rd[i] = wb_wd;
      end else if (branch_taken || lu) begin
         model_clear();
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 3) m_cnt_sat++;
      end else begin
         m_valid = in_valid;
         m_rw = in_valid & in_regwrite;
         m_mtr = in_valid & in_memtoreg;
         m_br = in_valid & in_branch;
         m_ext = in_ext; m_wa = in_wa; m_ctrl = in_ctrl; m_cond = in_cond;
         for (int i = 0; i < NREAD; i++) begin
            m_ra[i] = src(i);
            m_rd[i] = wb_hits(src(i)) ? wb_wd : in_rd[i*DATA_W +: DATA_W];
         end
      end
   endtask

   task automatic check_outputs();
      logic [NREAD*DATA_W-1:0] erd;
      logic [NREAD*ADDR_W-1:0] era;
      for (int i = 0; i < NREAD; i++) begin
         erd[i*DATA_W +: DATA_W] = m_rd[i];
         era[i*ADDR_W +: ADDR_W] = m_ra[i];
      end
      check("out_valid", out_valid, m_valid);
      check("out_regwrite", out_regwrite, m_rw);
      check("out_memtoreg", out_memtoreg, m_mtr);
      check("out_branch", out_branch, m_br);
      check("out_rd", out_rd, erd);
      check("out_ra", out_ra, era);
      check("out_ext", out_ext, m_ext);
      check("out_wa", out_wa, m_wa);
      check("out_ctrl", out_ctrl, m_ctrl);
      check("out_cond", out_cond, m_cond);
      check("bubble_cnt", bubble_cnt, m_cnt);
      check("bubble_cnt_sat", s_cnt, m_cnt_sat);
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic cycle();
      logic lu;
      #1;
      lu = model_lu();
      check("stall_d", stall_d, ex_stall || (!branch_taken && lu));
      check("flush_d", flush_d, !ex_stall && branch_taken);
      @(posedge clk);
      model_edge(lu);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic rand_instr();
      in_valid = 1'b1;
      for (int i = 0; i < NREAD; i++) begin
         in_ra[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
         in_rd[i*DATA_W +: DATA_W] = $urandom;
      end
      in_ra_used = '1;
      in_ext = $urandom; in_wa = ADDR_W'($urandom); in_ctrl = CTRL_W'($urandom);
      in_cond = 4'($urandom);
      in_regwrite = 1'($urandom); in_memtoreg = 1'($urandom); in_branch = 1'($urandom);
      ex_stall = 0; branch_taken = 0; wb_we = 0; wb_wa = '0; wb_wd = '0;
   endtask

   task automatic set_ra(input logic [ADDR_W-1:0] a0, a1, a2);
      in_ra = {a2, a1, a0};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_clear(); m_cnt = 0; m_cnt_sat = 0;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      rand_instr();
      in_valid = 0;
      do_reset();

      // Capture with same-cycle writeback bypass.
      rand_instr(); in_regwrite = 0; set_ra(3, 4, 6);
      in_rd[DATA_W-1:0] = 32'h11; wb_we = 1; wb_wa = 3; wb_wd = 32'hAB;
      cycle();
      check("bypass_rd0", out_rd[DATA_W-1:0], 32'hAB);
      check("bypass_valid", out_valid, 1'b1);

      // Load to r5 followed by a consumer of r5.
      rand_instr(); in_wa = 5; in_regwrite = 1; in_memtoreg = 1; set_ra(1, 2, 3);
      cycle();
      rand_instr(); set_ra(0, 5, 0); in_ra_used = 3'b010;
      #1 check("lu_stall_d", stall_d, 1'b1);
      cycle();
      check("lu_bubble_valid", out_valid, 1'b0);
      check("lu_bubble_cnt", bubble_cnt, 16'd1);
      cycle();
      check("lu_recapture", out_valid, 1'b1);

      // Taken branch flushes decode.
      rand_instr(); in_regwrite = 0; branch_taken = 1;
      #1 check("br_flush_d", flush_d, 1'b1);
      check("br_stall_d", stall_d, 1'b0);
      cycle();
      check("br_bubble_valid", out_valid, 1'b0);
      check("br_bubble_cnt", bubble_cnt, 16'd2);

      // ex_stall overrides branch and load-use; held operands track writeback.
      rand_instr(); in_wa = 5; in_regwrite = 1; in_memtoreg = 1; set_ra(7, 8, 9);
      cycle();
      for (int k = 0; k < 3; k++) begin
         rand_instr(); set_ra(5, 5, 5); ex_stall = 1; branch_taken = 1;
         if (k == 1) begin wb_we = 1; wb_wa = 7; wb_wd = 32'hCAFE; end
         cycle();
      end
      check("stall_cnt_hold", bubble_cnt, 16'd2);
      check("stall_wb_rd0", out_rd[DATA_W-1:0], 32'hCAFE);
      check("stall_wa_hold", out_wa, 4'd5);

      // Load to the PC register raises no hazard and is not bypassed.
      rand_instr(); in_wa = 4'(PC); in_regwrite = 1; in_memtoreg = 1; set_ra(1, 2, 3);
      cycle();
      rand_instr(); set_ra(4'(PC), 4'(PC), 4'(PC));
      wb_we = 1; wb_wa = 4'(PC); wb_wd = 32'hDEAD; in_rd[DATA_W-1:0] = 32'h22;
      #1 check("pc_no_stall", stall_d, 1'b0);
      cycle();
      check("pc_capture", out_valid, 1'b1);
      check("pc_no_bypass", out_rd[DATA_W-1:0], 32'h22);

      // Saturation of the 2-bit counter after four flushes.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         rand_instr(); branch_taken = 1;
         cycle();
         check("sat_cnt", s_cnt, (k < 3) ? 2'(k + 1) : 2'd3);
      end

      // Asynchronous reset mid-cycle, then release during a stall.
      rand_instr();
      cycle();
      rand_instr(); ex_stall = 1;
      #2 reset = 1'b1;
      #1;
      model_clear(); m_cnt = 0; m_cnt_sat = 0;
      check("async_valid", out_valid, 1'b0);
      check("async_cnt", bubble_cnt, 16'd0);
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      rand_instr();
      cycle();
      check("post_reset_capture", out_valid, 1'b1);

      // Randomized traffic biased toward hazards and bypasses.
      for (int n = 0; n < 400; n++) begin
         rand_instr();
         in_valid = ($urandom_range(0, 7) != 0);
         in_ra_used = NREAD'($urandom);
         for (int i = 0; i < NREAD; i++) begin
            case ($urandom_range(0, 3))
               0: in_ra[i*ADDR_W +: ADDR_W] = m_wa;
               1: in_ra[i*ADDR_W +: ADDR_W] = 4'(PC);
               default: ;
            endcase
         end
         in_memtoreg = ($urandom_range(0, 1) == 0);
         ex_stall = ($urandom_range(0, 4) == 0);
         branch_taken = ($urandom_range(0, 5) == 0);
         wb_we = 1'($urandom);
         wb_wa = ($urandom_range(0, 1) == 0) ? m_ra[$urandom_range(0, NREAD - 1)]
                                             : ADDR_W'($urandom);
         wb_wd = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
